// File: rtl/magic_packet_checker_pkg.sv
// Shared types and sizing helpers for the magic-packet checker and its sub-blocks.
package magic_packet_checker_pkg;

    // Checker FSM states.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StTrack = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH = 8;

    // Occupancy counters need one extra bit so that occ==DEPTH is representable.
    function automatic int unsigned occ_width(input int unsigned depth);
        occ_width = $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/magic_packet_checker_if.sv
// Snooped FIFO handshake/data path plus the checker's report signals.
interface magic_packet_checker_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             armed;
    logic             captured;
    logic             data_out_vld;
    logic             pass;
    logic             fail;
    logic             proto_err;
    logic [WIDTH-1:0] magic_data;

    // Harness side: drives the FIFO activity, observes the verdict.
    modport master (
        output start, push, pop, data_in, data_out,
        input  armed, captured, data_out_vld, pass, fail, proto_err, magic_data
    );

    // Checker side.
    modport slave (
        input  start, push, pop, data_in, data_out,
        output armed, captured, data_out_vld, pass, fail, proto_err, magic_data
    );
endinterface

// File: rtl/fifo_occ_counter.sv
// Mirrors a FIFO's occupancy from its push/pop requests and qualifies them
// against full/empty. Reusable by any scoreboard stage snooping the FIFO.
module fifo_occ_counter #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    output logic [CNT_W-1:0] occ,
    output logic             full,
    output logic             empty,
    output logic             push_fire,
    output logic             pop_fire
);
    logic [CNT_W-1:0] r_occ;

    assign full      = (r_occ == CNT_W'(DEPTH));
    assign empty     = (r_occ == '0);
    assign push_fire = push & ~full;
    assign pop_fire  = pop & ~empty;
    assign occ       = r_occ;

    // Track occupancy; simultaneous push+pop leaves it unchanged, qualifiers prevent wrap.
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_occ <= '0;
        end else if (push_fire && !pop_fire) begin
            r_occ <= r_occ + CNT_W'(1);
        end else if (pop_fire && !push_fire) begin
            r_occ <= r_occ - CNT_W'(1);
        end
    end

endmodule

// File: rtl/magic_packet_checker.sv
// Captures one "magic" packet on its accepted push into the scoreboard FIFO,
// counts the entries queued ahead of it, and compares the FIFO output on the
// pop that retires it. Sticky pass/fail/proto_err flags report the verdict.
// Build option: define MAGIC_PACKET_CHECKER_REARM_EN to allow start in DONE
// to re-arm the checker without a reset.
module magic_packet_checker
    import magic_packet_checker_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned CNT_W = occ_width(DEPTH)
) (
    input  logic                 CLK,
    input  logic                 rst,
    magic_packet_checker_if.slave bus
);
    state_e           r_state;
    logic [CNT_W-1:0] r_ahead;
    logic [WIDTH-1:0] r_magic_data;
    logic             r_pass;
    logic             r_fail;
    logic             r_proto_err;

    logic [CNT_W-1:0] w_occ;
    logic             w_full;
    logic             w_empty;
    logic             w_push_fire;
    logic             w_pop_fire;
    logic             w_ahead_zero;
    logic             w_match;
    logic             w_magic_pop;
    logic             w_proto_evt;

    fifo_occ_counter #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_occ (
        .CLK       (CLK),
        .rst       (rst),
        .push      (bus.push),
        .pop       (bus.pop),
        .occ       (w_occ),
        .full      (w_full),
        .empty     (w_empty),
        .push_fire (w_push_fire),
        .pop_fire  (w_pop_fire)
    );

    assign w_ahead_zero = (r_ahead == '0);
    assign w_match      = (bus.data_out == r_magic_data);
    // The pop that retires the magic packet: nothing left ahead of it.
    assign w_magic_pop  = (r_state == StTrack) && w_ahead_zero && w_pop_fire;
    assign w_proto_evt  = (bus.push & w_full) | (bus.pop & w_empty);

    assign bus.armed        = (r_state == StArmed);
    assign bus.captured     = (r_state == StTrack) || (r_state == StDone);
    assign bus.data_out_vld = w_magic_pop;
    assign bus.pass         = r_pass;
    assign bus.fail         = r_fail;
    assign bus.proto_err    = r_proto_err;
    assign bus.magic_data   = r_magic_data;

    // Checker FSM with its counters and sticky verdict flags.
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_state      <= StIdle;
            r_ahead      <= '0;
            r_magic_data <= '0;
            r_pass       <= 1'b0;
            r_fail       <= 1'b0;
            r_proto_err  <= 1'b0;
        end else begin
            if (w_proto_evt) begin
                r_proto_err <= 1'b1;
            end
            unique case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        r_state <= StArmed;
                    end
                end
                StArmed: begin
                    if (w_push_fire) begin
                        r_magic_data <= bus.data_in;
                        // An entry popped in the same cycle is no longer ahead.
                        r_ahead      <= w_occ - CNT_W'(w_pop_fire);
                        r_state      <= StTrack;
                    end
                end
                StTrack: begin
                    if (w_pop_fire) begin
                        if (w_ahead_zero) begin
                            r_pass  <= w_match;
                            r_fail  <= ~w_match;
                            r_state <= StDone;
                        end else begin
                            r_ahead <= r_ahead - CNT_W'(1);
                        end
                    end
                end
                StDone: begin
`ifdef MAGIC_PACKET_CHECKER_REARM_EN
                    if (bus.start) begin
                        r_pass       <= 1'b0;
                        r_fail       <= 1'b0;
                        r_magic_data <= '0;
                        r_ahead      <= '0;
                        r_state      <= StArmed;
                    end
`endif
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_magic_packet_checker.sv
// Randomised and directed stimulus for magic_packet_checker, checked every
// cycle against a queue-based model of the snooped FIFO whose entries carry a
// "magic" tag.
module tb_magic_packet_checker;
    import magic_packet_checker_pkg::*;

    localparam int unsigned WIDTH = DEFAULT_WIDTH;
    localparam int unsigned DEPTH = DEFAULT_DEPTH;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    magic_packet_checker_if #(.WIDTH(WIDTH)) bus ();

    magic_packet_checker #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .CLK (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic             magic;
        logic [WIDTH-1:0] data;
    } entry_t;

    entry_t           q[$];
    bit               m_init;
    bit               m_armed, m_track, m_done, m_pass, m_fail, m_proto;
    logic [WIDTH-1:0] m_magic;
    int               errors = 0;
    int               checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("armed", 32'(bus.armed), 32'(m_armed));
        check("captured", 32'(bus.captured), 32'(m_track | m_done));
        check("pass", 32'(bus.pass), 32'(m_pass));
        check("fail", 32'(bus.fail), 32'(m_fail));
        check("proto_err", 32'(bus.proto_err), 32'(m_proto));
        check("magic_data", 32'(bus.magic_data), 32'(m_magic));
        check("pass_fail_excl", 32'(bus.pass & bus.fail), 32'd0);
    endtask

    // One clock cycle: check registered outputs, drive inputs, check the
    // combinational strobe, then advance the model across the rising edge.
    task automatic step(input bit r, input bit s, input bit pu, input bit po,
                        input logic [WIDTH-1:0] din, input bit corrupt);
        logic [WIDTH-1:0] dout;
        logic [WIDTH-1:0] flip;
        bit               full, empty, pf, qf, exp_vld;
        entry_t           e;

        @(negedge clk);
        if (m_init) check_outputs();

        flip = '0;
        flip[0] = corrupt;
        if (q.size() != 0) dout = q[0].data ^ flip;
        else               dout = WIDTH'($urandom);

        rst          = r;
        bus.start    = s;
        bus.push     = pu;
        bus.pop      = po;
        bus.data_in  = din;
        bus.data_out = dout;

        full    = (q.size() == DEPTH);
        empty   = (q.size() == 0);
        pf      = pu && !full;
        qf      = po && !empty;
        exp_vld = 1'b0;
        if (m_track && qf) exp_vld = q[0].magic;

        #1;
        if (m_init) check("data_out_vld", 32'(bus.data_out_vld), 32'(exp_vld));

        @(posedge clk);
        if (r) begin
            q.delete();
            m_armed = 0; m_track = 0; m_done = 0;
            m_pass  = 0; m_fail  = 0; m_proto = 0;
            m_magic = '0;
        end else begin
            if ((pu && full) || (po && empty)) m_proto = 1;
            if (qf) void'(q.pop_front());
            if (pf) begin
                e.magic = m_armed;
                e.data  = din;
                q.push_back(e);
            end
            if (m_armed) begin
                if (pf) begin
                    m_armed = 0;
                    m_track = 1;
                    m_magic = din;
                end
            end else if (m_track) begin
                if (exp_vld) begin
                    m_track = 0;
                    m_done  = 1;
                    m_pass  = (dout == m_magic);
                    m_fail  = !m_pass;
                end
            end else if (m_done) begin
`ifdef MAGIC_PACKET_CHECKER_REARM_EN
                if (s) begin
                    m_done  = 0;
                    m_armed = 1;
                    m_pass  = 0;
                    m_fail  = 0;
                    m_magic = '0;
                end
`endif
            end else if (s) begin
                m_armed = 1;
            end
        end
        m_init = 1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, '0, 0);
    endtask

    task automatic do_rst();
        step(1, 0, 0, 0, '0, 0);
    endtask

    task automatic do_push(input logic [WIDTH-1:0] d);
        step(0, 0, 1, 0, d, 0);
    endtask

    task automatic do_pop(input bit corrupt);
        step(0, 0, 0, 1, '0, corrupt);
    endtask

    task automatic do_start();
        step(0, 1, 0, 0, '0, 0);
    endtask

    initial begin
        m_init       = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.push     = 1'b0;
        bus.pop      = 1'b0;
        bus.data_in  = '0;
        bus.data_out = '0;

        // Arm on empty FIFO, matching pop.
        do_rst();
        do_start();
        do_push(8'hA5);
        do_pop(0);
        idle();

        // Two packets ahead of the magic one.
        do_rst();
        do_push(8'h11);
        do_push(8'h22);
        do_start();
        do_push(8'h5A);
        do_pop(0);
        do_pop(0);
        do_pop(0);
        idle();

        // Mismatch on the magic pop.
        do_rst();
        do_start();
        do_push(8'h3C);
        do_pop(1);
        idle();

        // Simultaneous push+pop at capture with three entries queued.
        do_rst();
        do_push(8'h01);
        do_push(8'h02);
        do_push(8'h03);
        do_start();
        step(0, 0, 1, 1, 8'h77, 0);
        do_pop(0);
        do_pop(0);
        do_pop(0);
        idle();

        // Push while full in ARMED, then pop while empty.
        do_rst();
        for (int i = 0; i < int'(DEPTH); i++) do_push(WIDTH'(i + 8'h40));
        do_start();
        do_push(8'hEE);
        idle();
        do_rst();
        do_pop(0);
        idle();

        // Reset while tracking with one entry ahead.
        do_rst();
        do_push(8'h99);
        do_start();
        do_push(8'h66);
        do_rst();
        idle();

`ifdef MAGIC_PACKET_CHECKER_REARM_EN
        // Re-arm from DONE.
        do_rst();
        do_start();
        do_push(8'h12);
        do_pop(1);
        idle();
        do_start();
        do_push(8'h34);
        do_pop(0);
        idle();
`endif

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 WIDTH'($urandom),
                 ($urandom_range(0, 3) == 0));
        end
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/magic_packet_checker.md
Name: magic_packet_checker

Overview:
- Downstream checking stage for the data-integrity scoreboard FIFO.
- Snoops the FIFO push/pop handshake and its data path, and captures one "magic" packet on its accepted push.
- Counts the entries queued ahead of that packet. Compares the FIFO output against the captured value on the pop that retires it.
- Reports a one-cycle check strobe plus sticky pass/fail and protocol-error flags to the formal/sim harness.

Parameters:
- WIDTH, 8, data word width (matches FIFO data_in/data_out)
- DEPTH, 8, FIFO entry count; power of two, at least 2
- CNT_W, $clog2(DEPTH)+1, width of the occupancy and ahead counters

Ports:
- CLK  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request to arm the checker (level, sampled in IDLE)
- push  in  1  FIFO push request
- pop  in  1  FIFO pop request
- data_in  in  WIDTH  FIFO write data
- data_out  in  WIDTH  FIFO read data; combinational from the read pointer, valid in the pop cycle
- armed  out  1  high in ARMED state
- captured  out  1  high once the magic packet is held (TRACK or DONE)
- data_out_vld  out  1  one-cycle strobe on the magic-packet pop
- pass  out  1  sticky: magic packet matched
- fail  out  1  sticky: magic packet mismatched
- proto_err  out  1  sticky: push while full, or pop while empty
- magic_data  out  WIDTH  captured packet value

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, occ=0, ahead=0, magic_data=0. All outputs are 0.
- Handshake qualifiers:
  - full = (occ==DEPTH), empty = (occ==0).
  - push_fire = push & !full; pop_fire = pop & !empty.
- Occupancy counter occ (CNT_W bits):
  - push_fire only: occ+1. pop_fire only: occ-1. Both or neither: unchanged.
  - Never wraps.
- FSM states: IDLE, ARMED, TRACK, DONE.
- IDLE:
  - start=1 -> ARMED next cycle. Capture is never in the same cycle as start sampling.
- ARMED:
  - On push_fire: magic_data<=data_in; ahead<=occ-pop_fire; -> TRACK.
  - push while full: no capture, stay ARMED.
- TRACK, on pop_fire:
  - ahead!=0: ahead-1.
  - ahead==0: this pop retires the magic packet. data_out_vld=1 that cycle (combinational from state, ahead and pop_fire). Next cycle pass<=(data_out==magic_data), fail<=!match, state -> DONE.
- TRACK, other events: push_fire does not change ahead.
- DONE:
  - pass/fail hold; data_out_vld stays 0.
  - Terminal until rst (see Optional Feature).
- proto_err: set on (push & full) | (pop & empty) in any state; cleared only by rst.
- Latency:
  - capture -> captured=1 next cycle.
  - Magic pop -> data_out_vld in the same cycle; pass/fail one cycle later.
- rst mid-operation: it dominates every event in the same cycle. All state, counters and flags clear; a tracking sequence in progress is abandoned.
- pass and fail are never both 1.

Optional Feature:
- Macro: MAGIC_PACKET_CHECKER_REARM_EN.
- Defined:
  - In DONE, start=1 -> ARMED next cycle.
  - pass, fail and magic_data clear; occ continues tracking.
  - proto_err is unaffected.
- Undefined: DONE ignores start; a new check needs rst.

Decomposition:
- Package magic_packet_checker_pkg:
  - state enum (IDLE/ARMED/TRACK/DONE, 2 bits).
  - DEFAULT_WIDTH=8 and DEFAULT_DEPTH=8 localparams.
  - Occupancy width function clog2(depth)+1.
- Sub-module fifo_occ_counter:
  - Inputs: CLK, rst, push, pop.
  - Outputs: occ, full, empty, push_fire, pop_fire.
  - Reused by other scoreboard stages.

Test Plan:
- Arm on empty FIFO: rst, start, push data_in=0xA5 -> captured=1, ahead=0. Pop with data_out=0xA5 -> data_out_vld pulse, pass=1 next cycle, fail=0.
- Packets ahead: push 0x11,0x22, then arm and push magic 0x5A (ahead=2). Three pops returning 0x11,0x22,0x5A -> data_out_vld only on the third pop, pass=1.
- Mismatch: capture 0x3C; the magic pop returns 0x3D -> fail=1, pass=0, data_out_vld one pulse.
- Simultaneous push+pop at capture with occ=3 -> ahead=2. Exactly two further pops precede the strobe; occ stays 3 in the capture cycle.
- Boundaries:
  - Fill to occ=8, ARMED, push=1 -> no capture, proto_err=1.
  - pop at occ=0 -> occ stays 0, proto_err=1.
- Reset mid-TRACK (ahead=1) -> next cycle: state IDLE, all outputs 0. With MAGIC_PACKET_CHECKER_REARM_EN: start in DONE -> armed=1, pass=fail=0.
